// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Purpose : Shared definitions for the MIPS fetch stage: next-PC select
//           codes, fetch controller state encodings and special instruction
//           words.
// Contents: PC_SRC_* (2-bit next-PC select), fetchState_t (FETCH_IDLE,
//           FETCH_RUN, FETCH_HALT), NOP_WORD, HALT_WORD_DEFAULT.
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam logic [1:0] PC_SRC_PC4    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_JR     = 2'b11;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'b00,
      FETCH_RUN  = 2'b01,
      FETCH_HALT = 2'b10
   } fetchState_t;

   localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_memory.sv
// ---------------------------------------------------------------------------
// instr_memory
// Purpose : Instruction memory, IMEM_DEPTH 32-bit words. Synchronous write
//           port for the debug loader, combinational read port for fetch.
//           Byte addresses; bits [1:0] are ignored. Reads beyond the end of
//           the array return HALT_WORD, writes beyond it are dropped.
//           Contents are not reset.
// Ports   : clk                         clock
//           writeEnable/writeAddr/writeData  debug write port
//           readAddr / readData         fetch read port (combinational)
// ---------------------------------------------------------------------------
module instr_memory
   import mips_pkg::*;
#(
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        writeEnable,
   input  logic [31:0] writeAddr,
   input  logic [31:0] writeData,
   input  logic [31:0] readAddr,
   output logic [31:0] readData
);

   localparam int IDX_W = $clog2(IMEM_DEPTH);

   logic [31:0] memArray [IMEM_DEPTH];

   logic             writeInRange;
   logic             readInRange;
   logic [IDX_W-1:0] writeIdx;
   logic [IDX_W-1:0] readIdx;

   // An address is in range when every bit above the word index is zero.
   assign writeInRange = (writeAddr[31:IDX_W+2] == '0);
   assign readInRange  = (readAddr[31:IDX_W+2] == '0);
   assign writeIdx     = writeAddr[IDX_W+1:2];
   assign readIdx      = readAddr[IDX_W+1:2];

   always_ff @(posedge clk) begin
      if (writeEnable && writeInRange) begin
         memArray[writeIdx] <= writeData;
      end
   end

   assign readData = readInRange ? memArray[readIdx] : HALT_WORD;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Purpose : IF stage and IF/ID pipeline register of the 5-stage MIPS
//           pipeline, with the instruction memory and a run/step/halt
//           controller. Optional build macro FETCH_COUNT_EN adds a
//           saturating count of real instructions loaded into IF/ID.
// Ports   : clk, reset (sync, active high)
//           i_enable (run level), i_step (single-fetch pulse in IDLE)
//           PCWrite, IFIDWrite (stall controls), i_flush (NOP into IF/ID)
//           i_pc_src, i_branch_target, i_jump_target, i_jr_target (next PC)
//           i_imem_we, i_imem_waddr, i_imem_wdata (debug load port)
//           o_pc, o_instr_ifid, o_pc4_ifid, o_halted, o_state
//           o_fetch_count (only with FETCH_COUNT_EN)
// ---------------------------------------------------------------------------
module fetch_stage
   import mips_pkg::*;
#(
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic        i_step,
   input  logic        PCWrite,
   input  logic        IFIDWrite,
   input  logic        i_flush,
   input  logic [1:0]  i_pc_src,
   input  logic [31:0] i_branch_target,
   input  logic [31:0] i_jump_target,
   input  logic [31:0] i_jr_target,
   input  logic        i_imem_we,
   input  logic [31:0] i_imem_waddr,
   input  logic [31:0] i_imem_wdata,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr_ifid,
   output logic [31:0] o_pc4_ifid,
   output logic        o_halted,
   output logic [1:0]  o_state
`ifdef FETCH_COUNT_EN
   ,
   output logic [31:0] o_fetch_count
`endif
);

   fetchState_t stateReg, stateNext;
   logic [31:0] pcReg, pcNext;
   logic [31:0] instrReg, instrNext;
   logic [31:0] pc4Reg, pc4Next;
   logic [31:0] fetchedWord;
   logic [31:0] pcPlus4;
   logic        go;
   logic        haltFetch;
   logic        loadInstr;
   logic        imemWe;

   // The debug loader may only modify memory while the core is not running.
   assign imemWe = i_imem_we && (stateReg != FETCH_RUN);

   instr_memory #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .HALT_WORD  (HALT_WORD)
   ) u_imem (
      .clk         (clk),
      .writeEnable (imemWe),
      .writeAddr   (i_imem_waddr),
      .writeData   (i_imem_wdata),
      .readAddr    (pcReg),
      .readData    (fetchedWord)
   );

   assign pcPlus4 = pcReg + 32'd4;
   assign go      = (stateReg == FETCH_RUN) || ((stateReg == FETCH_IDLE) && i_step);

   // HALT is only taken on a genuine advance: both stall controls open and
   // the fetch not being squashed by a redirect. A stalled or flushed HALT
   // word must not freeze the machine or clobber a held IF/ID entry.
   assign haltFetch = go && PCWrite && IFIDWrite && !i_flush && (fetchedWord == HALT_WORD);
   assign loadInstr = go && IFIDWrite && !i_flush && !haltFetch;

   always_comb begin
      stateNext = stateReg;
      pcNext    = pcReg;
      instrNext = instrReg;
      pc4Next   = pc4Reg;

      case (stateReg)
         FETCH_IDLE: if (i_enable)  stateNext = FETCH_RUN;
         FETCH_RUN:  if (!i_enable) stateNext = FETCH_IDLE;
         default:    stateNext = FETCH_HALT;
      endcase
      if (haltFetch) begin
         stateNext = FETCH_HALT;
      end

      // PC holds on the HALT fetch so o_pc points at the HALT word.
      if (go && PCWrite && !haltFetch) begin
         case (i_pc_src)
            PC_SRC_BRANCH: pcNext = i_branch_target;
            PC_SRC_JUMP:   pcNext = i_jump_target;
            PC_SRC_JR:     pcNext = i_jr_target;
            default:       pcNext = pcPlus4;
         endcase
      end

      // Flush beats IFIDWrite; HALT drains the pipe with bubbles.
      if ((stateReg == FETCH_HALT) || haltFetch || (go && i_flush)) begin
         instrNext = NOP_WORD;
         pc4Next   = 32'd0;
      end else if (loadInstr) begin
         instrNext = fetchedWord;
         pc4Next   = pcPlus4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= FETCH_IDLE;
         pcReg    <= RESET_PC;
         instrReg <= NOP_WORD;
         pc4Reg   <= 32'd0;
      end else begin
         stateReg <= stateNext;
         pcReg    <= pcNext;
         instrReg <= instrNext;
         pc4Reg   <= pc4Next;
      end
   end

`ifdef FETCH_COUNT_EN
   logic [31:0] fetchCountReg;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetchCountReg <= 32'd0;
      end else if (loadInstr && (fetchCountReg != 32'hFFFF_FFFF)) begin
         fetchCountReg <= fetchCountReg + 32'd1;
      end
   end

   assign o_fetch_count = fetchCountReg;
`endif

   assign o_pc         = pcReg;
   assign o_instr_ifid = instrReg;
   assign o_pc4_ifid   = pc4Reg;
   assign o_halted     = (stateReg == FETCH_HALT);
   assign o_state      = stateReg;

endmodule
